// File: rtl/spi_master.sv
// Single-clock SPI command master: shifts a 10-bit {op, payload} frame out MSB first
// and, for read-data frames, captures one byte from MISO before releasing SS_n.
module spi_master #(
    parameter int RD_WAIT    = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_RD_WAIT,
        ST_RX,
        ST_GAP
    } state_t;

    // The first RX cycle already separates the last frame bit from the first
    // MISO sample, so the explicit wait state covers only RD_WAIT-1 cycles.
    localparam logic [15:0] WAIT_LAST = 16'((RD_WAIT > 1) ? (RD_WAIT - 2) : 0);
    localparam logic [15:0] GAP_LAST  = 16'((GAP_CYCLES > 1) ? (GAP_CYCLES - 1) : 0);

    state_t      state;
    logic [9:0]  frame;
    logic        rd_op;
    logic [3:0]  cnt;
    logic [15:0] wcnt;
    logic [7:0]  rx_sr;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            frame    <= '0;
            rd_op    <= 1'b0;
            cnt      <= '0;
            wcnt     <= '0;
            rx_sr    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        frame <= {cmd_op, cmd_data};
                        rd_op <= (cmd_op == 2'b11);
                        SS_n  <= 1'b0;
                        MOSI  <= cmd_op[1];
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    MOSI  <= frame[9];
                    frame <= {frame[8:0], 1'b0};
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt == 4'd9) begin
                        cnt  <= '0;
                        wcnt <= '0;
                        MOSI <= 1'b0;
                        if (!rd_op) begin
                            SS_n  <= 1'b1;
                            state <= ST_GAP;
                        end else if (RD_WAIT > 1) begin
                            state <= ST_RD_WAIT;
                        end else begin
                            state <= ST_RX;
                        end
                    end else begin
                        MOSI  <= frame[9];
                        frame <= {frame[8:0], 1'b0};
                        cnt   <= cnt + 4'd1;
                    end
                end
                ST_RD_WAIT: begin
                    if (wcnt == WAIT_LAST) begin
                        wcnt  <= '0;
                        state <= ST_RX;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                ST_RX: begin
                    rx_sr <= {rx_sr[6:0], MISO};
                    if (cnt == 4'd7) begin
                        cnt      <= '0;
                        wcnt     <= '0;
                        rd_data  <= {rx_sr[6:0], MISO};
                        rd_valid <= 1'b1;
                        SS_n     <= 1'b1;
                        state    <= ST_GAP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (wcnt == GAP_LAST) begin
                        wcnt  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: RD_WAIT, default 1; idle cycles between the last frame bit and the first MISO sample, for read-data commands.
REQ-002 Parameter: GAP_CYCLES, default 2; minimum cycles SS_n stays high between frames.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  master can accept a command; high only in IDLE.
REQ-007 cmd_op  input  2  frame opcode: 00 write address, 01 write data, 10 read address, 11 read data.
REQ-008 cmd_data  input  8  frame payload (address, write data, or dummy for 11).
REQ-009 rd_data  output  8  byte captured from MISO during the last read-data frame.
REQ-010 rd_valid  output  1  one-cycle pulse; rd_data is new.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 SS_n  output  1  slave select to the SPI slave, active-low.
REQ-013 MOSI  output  1  serial data to the slave.
REQ-014 MISO  input  1  serial data from the slave.

Function
REQ-015 States: IDLE, START, SHIFT, RD_WAIT, RX, GAP.
REQ-016 Handshake: a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_op and cmd_data are latched into a 10-bit frame {cmd_op, cmd_data}.
REQ-017 cmd_valid outside IDLE is ignored and causes no side effects.
REQ-018 Cycle 1 after acceptance (START): SS_n=0, MOSI=cmd_op[1], the slave's command-check bit.
REQ-019 Cycles 2..11 (SHIFT): SS_n=0, MOSI=frame[9], frame[8] ... frame[0], one bit per cycle, MSB first; a 4-bit counter tracks the bits.
REQ-020 For op != 11: after cycle 11, go to GAP.
REQ-021 For op = 11: after SHIFT, stay RD_WAIT cycles with SS_n=0, MOSI=0, then enter RX.
REQ-022 RX lasts 8 cycles: SS_n=0, MOSI=0; MISO is sampled at the end of each cycle and shifted in MSB first.
REQ-023 GAP: SS_n=1, MOSI=0 for GAP_CYCLES cycles, then IDLE.
REQ-024 On entry to GAP from RX, rd_data is updated and rd_valid=1 for exactly that first GAP cycle.
REQ-025 rd_data holds its value until the next completed read-data frame; other ops never change it.
REQ-026 Total SS_n-low time: 11 cycles for op 00/01/10; 19+RD_WAIT-1 cycles for op 11 (19 at default).
REQ-027 SS_n, MOSI, rd_data and rd_valid are registered outputs; cmd_ready and busy decode directly from the state register.
REQ-028 Back-to-back commands: cmd_ready rises in the first IDLE cycle after GAP; the earliest next SS_n fall is GAP_CYCLES+1 cycles after SS_n rises.
REQ-029 MISO is ignored outside RX.

Reset
REQ-030 While rst=1 at a rising edge: state=IDLE, SS_n=1, MOSI=0, rd_valid=0, rd_data=8'h00, bit counters=0.
REQ-031 Reset mid-frame: SS_n=1 at the next edge, the frame is abandoned, no rd_valid, and rd_data is cleared.
REQ-032 rst takes priority over a simultaneous cmd_valid; that command is not accepted.

Verification
REQ-033 Reset: rst=1 for 2 cycles with cmd_valid=1 -> SS_n=1, MOSI=0, rd_valid=0, rd_data=00; after release cmd_ready=1, busy=0.
REQ-034 Write address: op=00, data=8'hCB -> SS_n low 11 cycles; MOSI sequence 0, then 0,0,1,1,0,0,1,0,1,1; then SS_n high for 2 cycles; no rd_valid.
REQ-035 Write data: op=01, data=8'hF3 -> MOSI 0, then 0,1,1,1,1,1,0,0,1,1; a slave model then holds F3 at address CB.
REQ-036 Read: op=10 with data=CB, then op=11 with data=0F; the slave model returns F3 -> MISO sampled over 8 RX cycles after 1 RD_WAIT cycle; rd_valid pulses once with rd_data=8'hF3; SS_n low for 19 cycles.
REQ-037 Back-to-back with cmd_valid held high: second command accepted exactly 3 cycles after the first frame's SS_n rises; cmd_valid during busy causes no change.
REQ-038 Reset in RX cycle 4 of a read-data frame -> SS_n=1 at the next edge, rd_valid never asserts, rd_data=00, state IDLE.
